// File: rtl/rr_grant_decoder_pkg.sv
// Shared definitions for the rotating-priority grant decoder: the gate delay unit,
// the FSM state encoding, the default requester count and the pointer wrap helper.
`timescale 1ns/1ps

`ifndef D
`define D 1
`endif

package rr_grant_decoder_pkg;

  localparam int N_DEFAULT = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Next highest-priority index after winner w, wrapping at n-1 back to 0.
  function automatic int wrap_inc(input int w, input int n);
    int nxt;
    nxt = w + 1;
    if (nxt >= n) begin
      nxt = 0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_grant_decoder_pick.sv
// Combinational rotating-priority search: the first asserted request found
// starting at ptr and wrapping modulo N wins.
`timescale 1ns/1ps

module rr_grant_decoder_pick #(
  parameter int N    = 3,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] win_id,
  output logic            win_valid
);

  int dist_s;
  int best_s;

  // Choose the requester with the smallest rotated distance from ptr.
  always_comb begin
    win_id    = {ID_W{1'b0}};
    win_valid = 1'b0;
    dist_s    = 0;
    best_s    = N;
    for (int j = 0; j < N; j++) begin
      dist_s = j - int'(ptr);
      if (dist_s < 0) begin
        dist_s = dist_s + N;
      end else begin
        dist_s = dist_s;
      end
      if (req[j] && (dist_s < best_s)) begin
        best_s    = dist_s;
        win_id    = ID_W'(j);
        win_valid = 1'b1;
      end else begin
        best_s    = best_s;
      end
    end
  end

endmodule

// File: rtl/rr_grant_decoder.sv
// Rotating-priority one-hot grant decoder with an OR-reduced any_req.
// Build macro GATE_DELAY_EN adds #`D delays to register updates and a delayed `or` for any_req.
`timescale 1ns/1ps

`ifdef GATE_DELAY_EN
`define RR_DLY #`D
`else
`define RR_DLY
`endif

module rr_grant_decoder
  import rr_grant_decoder_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic            any_req
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic            busy_q, busy_d;

  logic [ID_W-1:0] win_id_s;
  logic            win_valid_s;
  logic            any_red_s;
  logic            owner_req_s;

  rr_grant_decoder_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .win_id    (win_id_s),
    .win_valid (win_valid_s)
  );

  assign any_red_s   = |req;
  // grant_q is one-hot on the winner, so this picks out req[w].
  assign owner_req_s = |(req & grant_q);

`ifdef GATE_DELAY_EN
  or #(`D) u_any_or (any_req, any_red_s, 1'b0);
`else
  assign any_req = any_red_s;
`endif

  // Next-state and next-output computation for the IDLE/GRANT controller.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid_s) begin
          for (int i = 0; i < N; i++) begin
            grant_d[i] = (win_id_s == ID_W'(i));
          end
          grant_id_d = win_id_s;
          busy_d     = 1'b1;
          state_d    = ST_GRANT;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (done || !owner_req_s) begin
          grant_d = {N{1'b0}};
          busy_d  = 1'b0;
          ptr_d   = ID_W'(wrap_inc(int'(grant_id_q), N));
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        grant_d = {N{1'b0}};
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= `RR_DLY ST_IDLE;
      ptr_q      <= `RR_DLY {ID_W{1'b0}};
      grant_q    <= `RR_DLY {N{1'b0}};
      grant_id_q <= `RR_DLY {ID_W{1'b0}};
      busy_q     <= `RR_DLY 1'b0;
    end else begin
      state_q    <= `RR_DLY state_d;
      ptr_q      <= `RR_DLY ptr_d;
      grant_q    <= `RR_DLY grant_d;
      grant_id_q <= `RR_DLY grant_id_d;
      busy_q     <= `RR_DLY busy_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rr_grant_decoder.sv
// Self-checking bench for rr_grant_decoder (N=3): directed scenarios then random
// traffic, all compared against a behavioural round-robin model.
`timescale 1ns/1ps

module tb_rr_grant_decoder;

  localparam int N    = 3;
  localparam int ID_W = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic            done;
  logic [N-1:0]    grant;
  logic [ID_W-1:0] grant_id;
  logic            busy;
  logic            any_req;

  int checks;
  int errors;

  // Reference model state: who holds the resource and where the search starts.
  bit m_busy;
  int m_id;
  int m_ptr;

  rr_grant_decoder #(.N(N), .ID_W(ID_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .any_req  (any_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_busy) g = 3'(1 << m_id);
    return g;
  endfunction

  task automatic model_update(input logic r, input logic [N-1:0] rq, input logic d);
    int idx;
    if (r) begin
      m_busy = 1'b0; m_id = 0; m_ptr = 0;
    end else if (!m_busy) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (m_ptr + k) % N;
        if (((rq >> idx) & 3'd1) != 3'd0) begin
          m_busy = 1'b1;
          m_id   = idx;
        end
      end
    end else if (d || (((rq >> m_id) & 3'd1) == 3'd0)) begin
      m_busy = 1'b0;
      m_ptr  = (m_id + 1) % N;
    end
  endtask

  // One clock: drive at the negedge, check any_req, apply the edge, check outputs.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic d);
    rst = r; req = rq; done = d;
    #2;
    check_val("any_req", 32'(any_req), 32'(|rq));
    @(posedge clk);
    model_update(r, rq, d);
    @(negedge clk);
    check_val("grant", 32'(grant), 32'(model_grant()));
    check_val("grant_id", 32'(grant_id), 32'(m_id));
    check_val("busy", 32'(busy), 32'(m_busy));
    check_val("onehot", 32'((grant & (grant - 3'd1)) == 3'd0), 32'd1);
    check_val("id_range", 32'(int'(grant_id) < N), 32'd1);
    check_val("busy_vs_grant", 32'(busy), 32'(|grant));
  endtask

  initial begin
    checks = 0; errors = 0;
    m_busy = 1'b0; m_id = 0; m_ptr = 0;
    rst = 1'b1; req = 3'b111; done = 1'b0;
    @(negedge clk);

    // Reset with all requests high.
    step(1'b1, 3'b111, 1'b0);
    step(1'b1, 3'b111, 1'b0);
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);

    // Basic grant and release.
    step(1'b0, 3'b101, 1'b0);
    check_val("basic_g0", 32'(grant), 32'b001);
    step(1'b0, 3'b101, 1'b1);
    check_val("basic_rel", 32'(grant), 32'd0);
    step(1'b0, 3'b101, 1'b0);
    check_val("basic_g2", 32'(grant), 32'b100);
    check_val("basic_id2", 32'(grant_id), 32'd2);
    step(1'b0, 3'b000, 1'b1);

    // Rotation with requests held.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'b111, 1'b0);
      check_val("rot_grant", 32'(grant), 32'(1 << (i % N)));
      step(1'b0, 3'b111, 1'b1);
      check_val("rot_idle", 32'(grant), 32'd0);
    end

    // Abandon by dropping the owner's request.
    step(1'b0, 3'b111, 1'b0);
    check_val("abn_g1", 32'(grant), 32'b010);
    step(1'b0, 3'b101, 1'b0);
    check_val("abn_rel", 32'(grant), 32'd0);
    step(1'b0, 3'b111, 1'b0);
    check_val("abn_g2", 32'(grant), 32'b100);

    // Reset while granting returns ptr to 0.
    step(1'b1, 3'b111, 1'b0);
    check_val("mrst_grant", 32'(grant), 32'd0);
    step(1'b0, 3'b110, 1'b0);
    check_val("mrst_g1", 32'(grant), 32'b010);
    step(1'b0, 3'b000, 1'b0);

    // Idle edge cases.
    step(1'b0, 3'b000, 1'b0);
    check_val("edge_none", 32'(grant), 32'd0);
    step(1'b0, 3'b000, 1'b1);
    check_val("edge_done_idle", 32'(busy), 32'd0);
    step(1'b0, 3'b010, 1'b0);
    check_val("edge_g1", 32'(grant), 32'b010);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
